// File: rtl/compressor_tree_3to2_pipe.sv
// compressor_tree_3to2_pipe
// Registered carry-save (3:2) compressor tree. It reduces NUM_ELEMENTS unsigned
// BIT_LEN-bit terms to a redundant pair (C, S) such that
// (C + S) mod 2^BIT_LEN == (sum of terms) mod 2^BIT_LEN.
// Optional build macro COMPRESSOR_TREE_MIDPIPE_EN adds a register stage after
// level ceil(L/2) of the L-level tree. This raises the latency from 1 to 2.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - synchronous active-low reset (clears every stage)
//   in_valid  - qualifier for terms
//   terms     - NUM_ELEMENTS x BIT_LEN operands
//   out_valid - qualifier for C/S
//   C         - carry vector, already shifted into weight position
//   S         - sum vector
module compressor_tree_3to2_pipe #(
   parameter int unsigned NUM_ELEMENTS = 130,
   parameter int unsigned BIT_LEN      = 2052
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [BIT_LEN-1:0] terms [NUM_ELEMENTS],
   output logic               out_valid,
   output logic [BIT_LEN-1:0] C,
   output logic [BIT_LEN-1:0] S
);

   // Vector count after one 3:2 level: each triple yields 2 rows, and leftovers pass through.
   function automatic int unsigned next_count(input int unsigned n);
      return (n <= 2) ? n : 2 * (n / 3) + (n % 3);
   endfunction

   function automatic int unsigned num_levels(input int unsigned n);
      int unsigned cnt;
      int unsigned lv;
      cnt = n;
      lv  = 0;
      while (cnt > 2) begin
         cnt = next_count(cnt);
         lv  = lv + 1;
      end
      return lv;
   endfunction

   function automatic int unsigned level_count(input int unsigned n, input int unsigned lv);
      int unsigned cnt;
      cnt = n;
      for (int unsigned k = 0; k < lv; k++) cnt = next_count(cnt);
      return cnt;
   endfunction

   localparam int unsigned LEVELS    = num_levels(NUM_ELEMENTS);
   localparam int unsigned MID_LEVEL = (LEVELS + 1) / 2;

   // Stage 0 holds the raw terms. Stage i holds the output of reduction level i.
   // fwd is what the next level (or the output register) consumes.
   for (genvar i = 0; i <= LEVELS; i++) begin : g_stage
      localparam int unsigned N = level_count(NUM_ELEMENTS, i);
      logic [BIT_LEN-1:0] vec [N];
      logic [BIT_LEN-1:0] fwd [N];

      if (i == 0) begin : g_inp
         assign vec = terms;
      end else begin : g_csa
         localparam int unsigned NP = level_count(NUM_ELEMENTS, i - 1);
         localparam int unsigned T  = NP / 3;

         // Triple t becomes sum row 2t and carry row 2t+1. The carry's MSB is dropped.
         for (genvar t = 0; t < T; t++) begin : g_tri
            logic [BIT_LEN-1:0] a, b, c;
            assign a = g_stage[i-1].fwd[3*t];
            assign b = g_stage[i-1].fwd[3*t+1];
            assign c = g_stage[i-1].fwd[3*t+2];
            assign vec[2*t]   = a ^ b ^ c;
            assign vec[2*t+1] = ((a & b) | (a & c) | (b & c)) << 1;
         end

         // The leftover 1 or 2 vectors pass through unchanged, after the new rows.
         for (genvar r = 0; r < NP - 3 * T; r++) begin : g_pass
            assign vec[2*T+r] = g_stage[i-1].fwd[3*T+r];
         end
      end

`ifdef COMPRESSOR_TREE_MIDPIPE_EN
      if (i == MID_LEVEL) begin : g_mid
         // Mid-tree pipeline register. For LEVELS==0 this acts as an input register.
         always_ff @(posedge clk) begin
            if (!rst_n) fwd <= '{default: '0};
            else        fwd <= vec;
         end
      end else begin : g_thru
         assign fwd = vec;
      end
`else
      assign fwd = vec;
`endif
   end

   logic               valid_d;
   logic [BIT_LEN-1:0] c_d;
   logic [BIT_LEN-1:0] s_d;

`ifdef COMPRESSOR_TREE_MIDPIPE_EN
   logic mid_valid;

   // Carries the valid flag alongside the mid-tree stage.
   always_ff @(posedge clk) begin
      if (!rst_n) mid_valid <= 1'b0;
      else        mid_valid <= in_valid;
   end

   assign valid_d = mid_valid;
`else
   assign valid_d = in_valid;
`endif

   // The last level always comes from a triple, so slot 0 holds the sum and slot 1 holds the carry.
   assign s_d = g_stage[LEVELS].fwd[0];
   if (NUM_ELEMENTS >= 2) begin : g_c_two
      assign c_d = g_stage[LEVELS].fwd[1];
   end else begin : g_c_one
      assign c_d = '0;
   end

   // Output registers load every cycle. out_valid alone qualifies C/S.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         C         <= '0;
         S         <= '0;
      end else begin
         out_valid <= valid_d;
         C         <= c_d;
         S         <= s_d;
      end
   end

endmodule

// File: tb/tb_compressor_tree_3to2_pipe.sv
// Testbench for compressor_tree_3to2_pipe.
// It drives a default-size instance with random terms and checks it against a queue-based scoreboard.
// Four small 8-bit instances are held at constant directed operands.
module tb_compressor_tree_3to2_pipe;

   localparam int unsigned BIG_N = 130;
   localparam int unsigned BIG_W = 2052;
   localparam int unsigned TAIL  = BIG_W % 32;
`ifdef COMPRESSOR_TREE_MIDPIPE_EN
   localparam int unsigned LAT = 2;
`else
   localparam int unsigned LAT = 1;
`endif
   localparam int unsigned NUM_CYCLES = 10000;
   localparam int unsigned RESET_AT   = 6000;

   typedef struct {
      logic             valid;
      logic [BIG_W-1:0] sum;
      logic             in_reset;
   } exp_t;

   exp_t exp_q[$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic             in_valid;
   logic [BIG_W-1:0] big_terms [BIG_N];
   logic             big_out_valid;
   logic [BIG_W-1:0] big_c, big_s;

   logic [7:0] t3 [3];
   logic [7:0] t4 [4];
   logic [7:0] t1 [1];
   logic [7:0] t2 [2];
   logic       v3, v4, v1, v2;
   logic [7:0] c3, s3, c4, s4, c1, s1, c2, s2;

   compressor_tree_3to2_pipe u_big (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .terms(big_terms),
      .out_valid(big_out_valid), .C(big_c), .S(big_s));

   compressor_tree_3to2_pipe #(.NUM_ELEMENTS(3), .BIT_LEN(8)) u_n3 (
      .clk(clk), .rst_n(rst_n), .in_valid(1'b1), .terms(t3),
      .out_valid(v3), .C(c3), .S(s3));

   compressor_tree_3to2_pipe #(.NUM_ELEMENTS(4), .BIT_LEN(8)) u_n4 (
      .clk(clk), .rst_n(rst_n), .in_valid(1'b1), .terms(t4),
      .out_valid(v4), .C(c4), .S(s4));

   compressor_tree_3to2_pipe #(.NUM_ELEMENTS(1), .BIT_LEN(8)) u_n1 (
      .clk(clk), .rst_n(rst_n), .in_valid(1'b1), .terms(t1),
      .out_valid(v1), .C(c1), .S(s1));

   compressor_tree_3to2_pipe #(.NUM_ELEMENTS(2), .BIT_LEN(8)) u_n2 (
      .clk(clk), .rst_n(rst_n), .in_valid(1'b1), .terms(t2),
      .out_valid(v2), .C(c2), .S(s2));

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string tag, input logic [BIG_W-1:0] obs, input logic [BIG_W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h (low 64 bits) at %0t",
                  tag, obs[63:0], exp[63:0], $time);
      end
   endtask

   task automatic rand_terms();
      for (int unsigned i = 0; i < BIG_N; i++) begin
         for (int unsigned w = 0; w < BIG_W / 32; w++) big_terms[i][w*32 +: 32] = $urandom;
         big_terms[i][BIG_W-1 -: TAIL] = TAIL'($urandom);
      end
   endtask

   function automatic logic [BIG_W-1:0] ref_sum();
      logic [BIG_W-1:0] acc;
      acc = '0;
      for (int unsigned i = 0; i < BIG_N; i++) acc = acc + big_terms[i];
      return acc;
   endfunction

   // A reset edge flushes everything in flight. The next LAT outputs read as all-zero and invalid.
   task automatic push_reset();
      exp_t e;
      exp_q.delete();
      for (int unsigned k = 0; k < LAT; k++) begin
         e.valid    = 1'b0;
         e.sum      = '0;
         e.in_reset = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   initial begin
      exp_t e;
      t3 = '{8'h01, 8'h01, 8'h01};
      t4 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      t1 = '{8'hA5};
      t2 = '{8'h12, 8'h34};

      rst_n    = 1'b0;
      in_valid = 1'b1;
      rand_terms();
      push_reset();

      for (int unsigned cyc = 0; cyc < NUM_CYCLES; cyc++) begin
         @(negedge clk);
         if (exp_q.size() == LAT) begin
            e = exp_q.pop_front();
            check("big_valid", BIG_W'(big_out_valid), BIG_W'(e.valid));
            if (e.in_reset) begin
               check("big_c_rst", big_c, '0);
               check("big_s_rst", big_s, '0);
               check("n1_valid_rst", BIG_W'(v1), '0);
               check("n1_s_rst", BIG_W'(s1), '0);
            end else begin
               if (e.valid) check("big_sum", big_c + big_s, e.sum);
               check("n3_valid", BIG_W'(v3), BIG_W'(1'b1));
               check("n3_sum", BIG_W'(8'(c3 + s3)), BIG_W'(8'h03));
               check("n4_sum", BIG_W'(8'(c4 + s4)), BIG_W'(8'hFC));
               check("n1_s", BIG_W'(s1), BIG_W'(8'hA5));
               check("n1_c", BIG_W'(c1), '0);
               check("n2_sum", BIG_W'(8'(c2 + s2)), BIG_W'(8'h46));
            end
         end

         // Drive the stimulus for the next edge. Valid is held high around the mid-stream reset so that real data is in flight.
         rst_n = !(cyc < 2 || cyc == RESET_AT);
         if (cyc + 3 >= RESET_AT && cyc <= RESET_AT + 1) in_valid = 1'b1;
         else                                            in_valid = 1'($urandom_range(0, 1));
         rand_terms();
         if (!rst_n) begin
            push_reset();
         end else begin
            e.valid    = in_valid;
            e.sum      = ref_sum();
            e.in_reset = 1'b0;
            exp_q.push_back(e);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
